poly_sched_rr: RTL

Round-robin scheduler that shares one pipelined `((x*a)+b)*c` evaluation datapath among `NREQ` requesters.
- Arbitrates requests with a valid/ready handshake.
- Skew-aligns the late operands `b` and `c` to their pipeline stages.
- Tags each issued operation with the requester ID and returns results with that tag.
- Sits between requester logic and the shared datapath; the datapath stages are instantiated inside this block.

---
 rtl/poly_sched_pkg.sv | 18 +
 rtl/poly_sched_rr_arbiter.sv | 29 ++
 rtl/poly_sched_rr.sv | 125 ++++++++++++
 3 files changed

// File: rtl/poly_sched_pkg.sv
// poly_sched_pkg: shared width constants, derived-width helpers and the pipeline stage tag
package poly_sched_pkg;
  localparam int WLX_DEF = 6;
  localparam int WLA_DEF = 2;
  localparam int WLB_DEF = 3;
  localparam int WLC_DEF = 4;
  localparam int TAG_IDW = 3;
  function automatic int wl_add(input int a, input int b);
    return (a > b ? a : b) + 1;
  endfunction
  function automatic int id_w(input int n);
    return $clog2(n) > 1 ? $clog2(n) : 1;
  endfunction
  typedef struct packed {
    logic v;
    logic [TAG_IDW-1:0] id;
  } tag_t;
endpackage

// File: rtl/poly_sched_rr_arbiter.sv
// poly_sched_rr_arbiter: combinational round-robin pick of the first eligible index at or after ptr_i
module poly_sched_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW = 2
) (
  input  logic [NREQ-1:0] elig_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  gnt_idx_o,
  output logic            any_grant_o
);
  int idx;
  // scan from farthest to nearest so the nearest eligible index after the pointer wins
  always_comb begin
    gnt_o = '0;
    gnt_idx_o = '0;
    any_grant_o = 1'b0;
    idx = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(ptr_i) + k) % NREQ;
      if (elig_i[idx]) begin
        gnt_o = '0;
        gnt_o[idx] = 1'b1;
        gnt_idx_o = IDW'(idx);
        any_grant_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/poly_sched_rr.sv
// poly_sched_rr: round-robin scheduler over a shared ((x*a)+b)*c pipeline; POLY_SCHED_STATS_EN adds issue/idle counters
module poly_sched_rr import poly_sched_pkg::*; #(
  parameter int NREQ = 4,
  parameter int WLx = WLX_DEF,
  parameter int WLa = WLA_DEF,
  parameter int WLb = WLB_DEF,
  parameter int WLc = WLC_DEF,
  localparam int WLmul = WLx + WLa,
  localparam int WLadd = wl_add(WLmul, WLb),
  localparam int WLout = WLadd + WLc,
  localparam int IDW = id_w(NREQ)
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*WLx-1:0] x_in,
  input  logic [NREQ*WLa-1:0] a_in,
  input  logic [NREQ*WLb-1:0] b_in,
  input  logic [NREQ*WLc-1:0] c_in,
  output logic                res_valid,
  output logic [IDW-1:0]      res_id,
  output logic [WLout-1:0]    res_data,
  output logic [NREQ-1:0]     busy
`ifdef POLY_SCHED_STATS_EN
  ,
  output logic [15:0]         issue_count,
  output logic [15:0]         idle_count
`endif
);
  tag_t t0_q, t0_d, t1_q, t2_q;
  logic signed [WLx-1:0] x0_q, x0_d;
  logic signed [WLa-1:0] a0_q, a0_d;
  logic signed [WLb-1:0] b0_q, b0_d, b1_q;
  logic signed [WLc-1:0] c0_q, c0_d, c1_q, c2_q;
  logic signed [WLmul-1:0] mul1_q;
  logic signed [WLadd-1:0] add2_q;
  logic signed [WLout-1:0] res_data_q;
  logic res_valid_q;
  logic [IDW-1:0] res_id_q, rr_ptr_q, rr_ptr_d, gidx;
  logic [NREQ-1:0] busy_q, busy_d, retire_now, elig, gnt;
  logic any_grant, issue;
  // the op in stage 2 lands in stage 3 next edge, so its owner may issue again at that same edge
  always_comb for (int i = 0; i < NREQ; i++) retire_now[i] = t2_q.v && t2_q.id == TAG_IDW'(i);
  assign elig = req_valid & (~busy_q | retire_now);
  poly_sched_rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .elig_i(elig),
    .ptr_i(rr_ptr_q),
    .gnt_o(gnt),
    .gnt_idx_o(gidx),
    .any_grant_o(any_grant)
  );
  assign issue = any_grant & ~RST;
  assign req_ready = RST ? '0 : gnt;
  // next pointer, busy flags and operand capture from the granted requester
  always_comb begin
    rr_ptr_d = issue ? (gidx == IDW'(NREQ - 1) ? '0 : gidx + IDW'(1)) : rr_ptr_q;
    busy_d = (busy_q & ~retire_now) | req_ready;
    t0_d.v = issue;
    t0_d.id = TAG_IDW'(gidx);
    x0_d = issue ? x_in[int'(gidx)*WLx +: WLx] : x0_q;
    a0_d = issue ? a_in[int'(gidx)*WLa +: WLa] : a0_q;
    b0_d = issue ? b_in[int'(gidx)*WLb +: WLb] : b0_q;
    c0_d = issue ? c_in[int'(gidx)*WLc +: WLc] : c0_q;
  end
  // operand capture, then multiply / add (b skewed one stage) / multiply (c skewed two stages)
  always_ff @(posedge CLK)
    if (RST) begin
      rr_ptr_q <= '0;
      busy_q <= '0;
      t0_q <= '0;
      t1_q <= '0;
      t2_q <= '0;
      x0_q <= '0;
      a0_q <= '0;
      b0_q <= '0;
      c0_q <= '0;
      mul1_q <= '0;
      b1_q <= '0;
      c1_q <= '0;
      add2_q <= '0;
      c2_q <= '0;
      res_valid_q <= 1'b0;
      res_id_q <= '0;
      res_data_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      busy_q <= busy_d;
      t0_q <= t0_d;
      x0_q <= x0_d;
      a0_q <= a0_d;
      b0_q <= b0_d;
      c0_q <= c0_d;
      t1_q <= t0_q;
      mul1_q <= WLmul'(x0_q) * WLmul'(a0_q);
      b1_q <= b0_q;
      c1_q <= c0_q;
      t2_q <= t1_q;
      add2_q <= WLadd'(mul1_q) + WLadd'(b1_q);
      c2_q <= c1_q;
      res_valid_q <= t2_q.v;
      if (t2_q.v) begin
        res_id_q <= t2_q.id[IDW-1:0];
        res_data_q <= WLout'(add2_q) * WLout'(c2_q);
      end
    end
  assign res_valid = res_valid_q;
  assign res_id = res_id_q;
  assign res_data = res_data_q;
  assign busy = busy_q;
`ifdef POLY_SCHED_STATS_EN
  logic [15:0] issue_cnt_q, idle_cnt_q;
  // wrapping counters: issues, and cycles where someone asked but nothing issued
  always_ff @(posedge CLK)
    if (RST) begin
      issue_cnt_q <= '0;
      idle_cnt_q <= '0;
    end else begin
      issue_cnt_q <= issue_cnt_q + 16'(issue);
      idle_cnt_q <= idle_cnt_q + 16'(|req_valid && !issue);
    end
  assign issue_count = issue_cnt_q;
  assign idle_count = idle_cnt_q;
`endif
endmodule
